// File: rtl/gpio_pkg.sv
// Shared definitions for the GPIO controller: host bus geometry and
// register address map.
package gpio_pkg;

   localparam int DATA_W = 16;   // host register bus data width
   localparam int ADDR_W = 3;    // host register bus address width

   localparam logic [ADDR_W-1:0] ADDR_DIR      = 3'd0;
   localparam logic [ADDR_W-1:0] ADDR_OUT      = 3'd1;
   localparam logic [ADDR_W-1:0] ADDR_IN       = 3'd2;
   localparam logic [ADDR_W-1:0] ADDR_RISE_EN  = 3'd3;
   localparam logic [ADDR_W-1:0] ADDR_FALL_EN  = 3'd4;
   localparam logic [ADDR_W-1:0] ADDR_IRQ_STAT = 3'd5;
   localparam logic [ADDR_W-1:0] ADDR_OUT_SET  = 3'd6;
   localparam logic [ADDR_W-1:0] ADDR_OUT_CLR  = 3'd7;

endpackage

// File: rtl/gpio_if.sv
// Host register bus into the GPIO controller.
//   addr     register address
//   wr_en    one-cycle write strobe, wr_data write data
//   rd_en    one-cycle read strobe, rd_data registered read data
// master: host side, slave: gpio_ctrl side.
interface gpio_if;
   import gpio_pkg::*;

   logic [ADDR_W-1:0] addr;
   logic              wr_en;
   logic [DATA_W-1:0] wr_data;
   logic              rd_en;
   logic [DATA_W-1:0] rd_data;

   modport master (output addr, output wr_en, output wr_data, output rd_en, input rd_data);
   modport slave  (input addr, input wr_en, input wr_data, input rd_en, output rd_data);

endinterface

// File: rtl/gpio_sync_edge.sv
// Pad input synchronizer and edge detector.
//   clk, rst_n        clock, async active-low reset
//   pin_in            raw pad inputs (asynchronous to clk)
//   rise_en/fall_en   per-line edge enables
//   sync_out          synchronized input value (second flop)
//   rise/fall         qualified single-cycle edge pulses
module gpio_sync_edge #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] pin_in,
   input  logic [WIDTH-1:0] rise_en,
   input  logic [WIDTH-1:0] fall_en,
   output logic [WIDTH-1:0] sync_out,
   output logic [WIDTH-1:0] rise,
   output logic [WIDTH-1:0] fall
);

   logic [WIDTH-1:0] sync1_r;
   logic [WIDTH-1:0] sync2_r;
   logic [WIDTH-1:0] prev_r;
   logic [1:0]       warm_r;

   // two-flop synchronizer, previous-value register and saturating warm-up counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_r <= '0;
         sync2_r <= '0;
         prev_r  <= '0;
         warm_r  <= 2'd0;
      end else begin
         sync1_r <= pin_in;
         sync2_r <= sync1_r;
         prev_r  <= sync2_r;
         if (warm_r != 2'd3) begin
            warm_r <= warm_r + 2'd1;
         end else begin
            warm_r <= warm_r;
         end
      end
   end

   // edges are masked until prev holds a real sample, so lines that are
   // already high when reset releases do not look like rising edges
   always_comb begin
      rise = '0;
      fall = '0;
      if (warm_r == 2'd3) begin
         rise = sync2_r & ~prev_r & rise_en;
         fall = ~sync2_r & prev_r & fall_en;
      end else begin
         rise = '0;
         fall = '0;
      end
   end

   assign sync_out = sync2_r;

endmodule

// File: rtl/gpio_ctrl.sv
// Register-side GPIO controller: direction / output-data registers for the
// pad block, synchronized input readback, edge-triggered W1C interrupt status.
//   clk, rst_n   clock, async active-low reset
//   bus          host register bus (slave side)
//   gpio_dir     per-line output enable to pads
//   gpio_out     per-line drive value to pads
//   gpio_in      raw pad input values
//   irq          level interrupt, high while any status bit is set
module gpio_ctrl
   import gpio_pkg::*;
#(
   parameter int               WIDTH     = 8,
   parameter logic [WIDTH-1:0] DIR_RESET = '0,
   parameter logic [WIDTH-1:0] OUT_RESET = '0
) (
   input  logic             clk,
   input  logic             rst_n,
   gpio_if.slave            bus,
   output logic [WIDTH-1:0] gpio_dir,
   output logic [WIDTH-1:0] gpio_out,
   input  logic [WIDTH-1:0] gpio_in,
   output logic             irq
);

   logic [WIDTH-1:0]  dir_r;
   logic [WIDTH-1:0]  out_r;
   logic [WIDTH-1:0]  rise_en_r;
   logic [WIDTH-1:0]  fall_en_r;
   logic [WIDTH-1:0]  stat_r;
   logic [DATA_W-1:0] rd_data_r;

   logic [WIDTH-1:0]  wdata_s;
   logic [WIDTH-1:0]  clr_s;
   logic [WIDTH-1:0]  sync_s;
   logic [WIDTH-1:0]  rise_s;
   logic [WIDTH-1:0]  fall_s;
   logic [WIDTH-1:0]  rd_mux_s;
   logic [DATA_W-1:0] rd_next_s;
   logic              unused_wdata_s;

   // write data bits above WIDTH carry no meaning
   assign wdata_s        = bus.wr_data[WIDTH-1:0];
   assign unused_wdata_s = ^bus.wr_data;

   gpio_sync_edge #(.WIDTH(WIDTH)) u_sync_edge (
      .clk      (clk),
      .rst_n    (rst_n),
      .pin_in   (gpio_in),
      .rise_en  (rise_en_r),
      .fall_en  (fall_en_r),
      .sync_out (sync_s),
      .rise     (rise_s),
      .fall     (fall_s)
   );

   // host writes to the control registers, including set/clear aliases of OUT
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dir_r     <= DIR_RESET;
         out_r     <= OUT_RESET;
         rise_en_r <= '0;
         fall_en_r <= '0;
      end else if (bus.wr_en) begin
         case (bus.addr)
            ADDR_DIR:     dir_r     <= wdata_s;
            ADDR_OUT:     out_r     <= wdata_s;
            ADDR_RISE_EN: rise_en_r <= wdata_s;
            ADDR_FALL_EN: fall_en_r <= wdata_s;
            ADDR_OUT_SET: out_r     <= out_r | wdata_s;
            ADDR_OUT_CLR: out_r     <= out_r & ~wdata_s;
            default:      out_r     <= out_r;
         endcase
      end else begin
         out_r <= out_r;
      end
   end

   // W1C clear mask for the status register
   always_comb begin
      clr_s = '0;
      if (bus.wr_en && (bus.addr == ADDR_IRQ_STAT)) begin
         clr_s = wdata_s;
      end else begin
         clr_s = '0;
      end
   end

   // status latch: a new edge wins over a same-cycle clear of that bit
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stat_r <= '0;
      end else begin
         stat_r <= (stat_r & ~clr_s) | rise_s | fall_s;
      end
   end

   // read mux sees pre-write register values, so a same-cycle write is not visible
   always_comb begin
      rd_mux_s = '0;
      case (bus.addr)
         ADDR_DIR:      rd_mux_s = dir_r;
         ADDR_OUT:      rd_mux_s = out_r;
         ADDR_IN:       rd_mux_s = sync_s;
         ADDR_RISE_EN:  rd_mux_s = rise_en_r;
         ADDR_FALL_EN:  rd_mux_s = fall_en_r;
         ADDR_IRQ_STAT: rd_mux_s = stat_r;
         ADDR_OUT_SET:  rd_mux_s = '0;
         ADDR_OUT_CLR:  rd_mux_s = '0;
         default:       rd_mux_s = '0;
      endcase
      rd_next_s              = '0;
      rd_next_s[WIDTH-1:0]   = rd_mux_s;
   end

   // read data register, held between read strobes
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_data_r <= '0;
      end else if (bus.rd_en) begin
         rd_data_r <= rd_next_s;
      end else begin
         rd_data_r <= rd_data_r;
      end
   end

   assign bus.rd_data = rd_data_r;
   assign gpio_dir    = dir_r;
   assign gpio_out    = out_r;
   assign irq         = |stat_r;

endmodule

// File: tb/tb_gpio_ctrl.sv
// Directed self-checking bench for gpio_ctrl (WIDTH=8, zero reset values).
module tb_gpio_ctrl;
   import gpio_pkg::*;

   logic       clk;
   logic       rst_n;
   logic [7:0] gpio_dir;
   logic [7:0] gpio_out;
   logic [7:0] gpio_in;
   logic       irq;

   int n_checks;
   int n_fail;

   logic [15:0] rd_val;

   gpio_if bus ();

   gpio_ctrl #(.WIDTH(8), .DIR_RESET(8'h00), .OUT_RESET(8'h00)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .bus      (bus.slave),
      .gpio_dir (gpio_dir),
      .gpio_out (gpio_out),
      .gpio_in  (gpio_in),
      .irq      (irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // advance to just after the next rising edge
   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wr(input logic [2:0] a, input logic [15:0] d);
      bus.addr    = a;
      bus.wr_data = d;
      bus.wr_en   = 1'b1;
      tick(1);
      bus.wr_en   = 1'b0;
   endtask

   task automatic rd(input logic [2:0] a, output logic [15:0] d);
      bus.addr  = a;
      bus.rd_en = 1'b1;
      tick(1);
      bus.rd_en = 1'b0;
      d = bus.rd_data;
   endtask

   initial begin
      n_checks    = 0;
      n_fail      = 0;
      rst_n       = 1'b0;
      gpio_in     = 8'hFF;
      bus.addr    = 3'd0;
      bus.wr_en   = 1'b0;
      bus.wr_data = 16'h0000;
      bus.rd_en   = 1'b0;

      // reset state
      tick(2);
      check("rst_dir", {24'd0, gpio_dir}, 32'h00);
      check("rst_out", {24'd0, gpio_out}, 32'h00);
      check("rst_irq", {31'd0, irq}, 32'h0);
      check("rst_rd",  {16'd0, bus.rd_data}, 32'h0000);
      rst_n = 1'b1;

      // pins high through reset must not fake a rising edge
      wr(ADDR_RISE_EN, 16'h00FF);
      tick(6);
      check("warm_irq", {31'd0, irq}, 32'h0);
      rd(ADDR_IRQ_STAT, rd_val);
      check("warm_stat", {16'd0, rd_val}, 32'h0000);
      rd(ADDR_IN, rd_val);
      check("in_read", {16'd0, rd_val}, 32'h00FF);

      // direction / output registers and set/clear aliases
      wr(ADDR_DIR, 16'hFF0F);
      wr(ADDR_OUT, 16'h00A5);
      wr(ADDR_OUT_SET, 16'h0010);
      wr(ADDR_OUT_CLR, 16'h0005);
      check("dir_pin", {24'd0, gpio_dir}, 32'h0F);
      check("out_pin", {24'd0, gpio_out}, 32'hB0);
      rd(ADDR_DIR, rd_val);
      check("dir_read_hi0", {16'd0, rd_val}, 32'h000F);
      rd(ADDR_OUT, rd_val);
      check("out_read", {16'd0, rd_val}, 32'h00B0);
      rd(ADDR_OUT_SET, rd_val);
      check("set_read0", {16'd0, rd_val}, 32'h0000);
      rd(ADDR_OUT_CLR, rd_val);
      check("clr_read0", {16'd0, rd_val}, 32'h0000);

      // single rising edge on bit 0: status at edge N+2
      wr(ADDR_RISE_EN, 16'h0001);
      gpio_in = 8'h00;
      tick(5);
      check("quiet_irq", {31'd0, irq}, 32'h0);
      gpio_in = 8'h01;
      tick(1);   // edge N samples the change
      check("rise_n0", {31'd0, irq}, 32'h0);
      tick(1);   // edge N+1
      check("rise_n1", {31'd0, irq}, 32'h0);
      tick(1);   // edge N+2
      check("rise_n2", {31'd0, irq}, 32'h1);
      // glitch on a line whose rise is disabled
      gpio_in = 8'h03;
      tick(1);
      gpio_in = 8'h01;
      tick(5);
      rd(ADDR_IRQ_STAT, rd_val);
      check("rise_stat", {16'd0, rd_val}, 32'h0001);
      wr(ADDR_IRQ_STAT, 16'h0001);
      check("w1c_irq", {31'd0, irq}, 32'h0);

      // falling edge on bit 7 colliding with a W1C of that bit
      wr(ADDR_FALL_EN, 16'h0080);
      gpio_in = 8'h81;
      tick(5);
      check("no_fall_irq", {31'd0, irq}, 32'h0);
      gpio_in = 8'h01;
      tick(2);   // edges N, N+1
      wr(ADDR_IRQ_STAT, 16'h0080);   // strobe at edge N+2
      check("coll_irq", {31'd0, irq}, 32'h1);
      rd(ADDR_IRQ_STAT, rd_val);
      check("coll_stat", {16'd0, rd_val}, 32'h0080);
      wr(ADDR_IRQ_STAT, 16'h0080);
      check("clr_irq", {31'd0, irq}, 32'h0);

      // read and write OUT in the same cycle
      wr(ADDR_OUT, 16'h0011);
      bus.addr    = ADDR_OUT;
      bus.wr_data = 16'h0022;
      bus.wr_en   = 1'b1;
      bus.rd_en   = 1'b1;
      tick(1);
      bus.wr_en   = 1'b0;
      bus.rd_en   = 1'b0;
      check("rw_old", {16'd0, bus.rd_data}, 32'h0011);
      check("rw_pin", {24'd0, gpio_out}, 32'h22);
      rd(ADDR_OUT, rd_val);
      check("rw_new", {16'd0, rd_val}, 32'h0022);
      bus.addr = ADDR_IN;
      tick(3);
      check("rd_hold", {16'd0, bus.rd_data}, 32'h0022);

      // async reset mid-sequence with irq raised
      gpio_in = 8'h00;
      tick(3);
      gpio_in = 8'h01;
      tick(4);
      wr(ADDR_DIR, 16'h00FF);
      check("pre_rst_irq", {31'd0, irq}, 32'h1);
      check("pre_rst_dir", {24'd0, gpio_dir}, 32'hFF);
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_irq", {31'd0, irq}, 32'h0);
      check("arst_dir", {24'd0, gpio_dir}, 32'h00);
      check("arst_out", {24'd0, gpio_out}, 32'h00);
      check("arst_rd",  {16'd0, bus.rd_data}, 32'h0000);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
